pow_mult_seq: RTL



---
 rtl/sfgen_arith_pkg.sv | 14 +
 rtl/mult_trunc.sv | 13 +
 rtl/pow_mult_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/sfgen_arith_pkg.sv
// Shared arithmetic types for the sequential power-multiply stage.
// FSM state encoding plus default widths.
package sfgen_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } pow_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mult_trunc.sv
// Combinational WIDTH x WIDTH multiplier keeping only the low WIDTH bits.
// The upper half of the product never affects the result, so it is not formed.
module mult_trunc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  assign z = WIDTH'(x * y);

endmodule

// File: rtl/pow_mult_seq.sv
// Handshaked sequential a * b^EXP (mod 2^WIDTH) using one shared multiplier.
// A new operand pair may load on the same edge a finished result is consumed.
module pow_mult_seq
  import sfgen_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int EXP   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam bit               EXP0  = (EXP == 0);

  pow_state_t       state;
  pow_state_t       nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] prod;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             give;

  assign take = in_valid & in_ready;
  assign give = out_valid & out_ready;

  mult_trunc #(
    .WIDTH(WIDTH)
  ) u_mul (
    .x(acc),
    .y(base),
    .z(prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (take) nxt = EXP0 ? DONE : MUL;
      end
      MUL: begin
        if (cnt == ONE_C) nxt = DONE;
      end
      DONE: begin
        if (take)      nxt = EXP0 ? DONE : MUL;
        else if (give) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) |
                ((state == DONE) & out_ready);
    out       = acc;
  end

  // Loading takes priority; it can only coincide with IDLE or a consumed DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      base <= '0;
      cnt  <= '0;
    end else if (take) begin
      acc  <= a;
      base <= b;
      cnt  <= EXP_C;
    end else if (state == MUL) begin
      acc  <= prod;
      cnt  <= cnt - ONE_C;
    end
  end

endmodule
